// File: rtl/x_capture_monitor_pkg.sv
// Shared types for the X capture monitor.
// Buffer state encoding lives here.
package x_capture_monitor_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/x_capture_monitor_x_detect.sv
// Flags any X or Z bit on a 4-state vector.
// XOR-reduce turns a single unknown bit into X.
module x_detect #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] d,
  output logic             unknown
);

  assign unknown = ((^d) === 1'bx);

endmodule

// File: rtl/x_capture_monitor.sv
// One-entry capture buffer that tags samples
// carrying X/Z and keeps saturating statistics.
module x_capture_monitor
  import x_capture_monitor_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_unknown,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] x_cnt,
  output logic             x_seen,
  output logic             ctrl_x
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t state;
  logic   d_x;
  logic   v_x;
  logic   r_x;
  logic   vld;
  logic   rdy;
  logic   acc;

  x_detect #(.WIDTH(WIDTH)) u_dx (
    .d       (in_data),
    .unknown (d_x)
  );

  x_detect #(.WIDTH(1)) u_vx (
    .d       (in_valid),
    .unknown (v_x)
  );

  x_detect #(.WIDTH(1)) u_rx (
    .d       (out_ready),
    .unknown (r_x)
  );

  // Unknown handshake bits collapse to 0
  assign vld = in_valid & ~v_x;
  assign rdy = out_ready & ~r_x;

  assign in_ready = (state == EMPTY)
                  | ((state == FULL) & rdy);
  assign acc       = vld & in_ready;
  assign out_valid = (state == FULL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= EMPTY;
      out_data    <= '0;
      out_unknown <= 1'b0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (acc) begin
            state       <= FULL;
            out_data    <= in_data;
            out_unknown <= d_x;
          end
        end
        FULL: begin
          if (acc) begin
            out_data    <= in_data;
            out_unknown <= d_x;
          end else if (rdy) begin
            state <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt <= '0;
      x_cnt      <= '0;
      x_seen     <= 1'b0;
      ctrl_x     <= 1'b0;
    end else if (cnt_clr) begin
      sample_cnt <= '0;
      x_cnt      <= '0;
      x_seen     <= 1'b0;
      ctrl_x     <= 1'b0;
    end else begin
      if (acc && sample_cnt != CNT_MAX)
        sample_cnt <= sample_cnt + 1'b1;
      if (acc && d_x && x_cnt != CNT_MAX)
        x_cnt <= x_cnt + 1'b1;
      if (acc && d_x)
        x_seen <= 1'b1;
      if (v_x || r_x)
        ctrl_x <= 1'b1;
    end
  end

endmodule

// File: tb/tb_x_capture_monitor.sv
// Directed bench for x_capture_monitor.
// X-dependent checks run only on 4-state sims.
module tb_x_capture_monitor;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [0:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [0:0] out_data;
  logic       out_unknown;
  logic       cnt_clr;
  logic [1:0] sample_cnt;
  logic [1:0] x_cnt;
  logic       x_seen;
  logic       ctrl_x;

  int  n_tests = 0;
  int  n_fail  = 0;
  logic probe;
  bit  four_state;

  x_capture_monitor #(
    .WIDTH (1),
    .CNT_W (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_unknown (out_unknown),
    .cnt_clr     (cnt_clr),
    .sample_cnt  (sample_cnt),
    .x_cnt       (x_cnt),
    .x_seen      (x_seen),
    .ctrl_x      (ctrl_x)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    probe      = 1'bx;
    four_state = (probe === 1'bx);

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 1'b0;
    out_ready = 1'b0;
    cnt_clr   = 1'b0;

    #3;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready",  32'(in_ready),  1);
    chk("rst_sample",    32'(sample_cnt), 0);
    chk("rst_ctrl_x",    32'(ctrl_x),    0);
    step();
    rst_n = 1'b1;
    step();
    chk("idle_empty", 32'(out_valid), 0);

    // known sample, one-cycle latency
    in_valid = 1'b1;
    in_data  = 1'b1;
    step();
    in_valid = 1'b0;
    chk("k_out_valid", 32'(out_valid),   1);
    chk("k_out_data",  32'(out_data),    1);
    chk("k_unknown",   32'(out_unknown), 0);
    chk("k_sample",    32'(sample_cnt),  1);
    chk("k_xcnt",      32'(x_cnt),       0);
    chk("k_in_ready",  32'(in_ready),    0);

    // back-pressure then replace
    in_valid = 1'b1;
    in_data  = 1'b0;
    #1;
    chk("bp_in_ready", 32'(in_ready), 0);
    step();
    chk("bp_hold",     32'(out_data),   1);
    chk("bp_sample",   32'(sample_cnt), 1);
    out_ready = 1'b1;
    #1;
    chk("rp_in_ready", 32'(in_ready), 1);
    step();
    chk("rp_valid",  32'(out_valid),  1);
    chk("rp_data",   32'(out_data),   0);
    chk("rp_sample", 32'(sample_cnt), 2);
    in_valid = 1'b0;
    step();
    chk("drain_empty", 32'(out_valid), 0);

    // saturation and clear-with-accept
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("clr_sample", 32'(sample_cnt), 0);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = 1'(i);
      step();
    end
    chk("sat_sample", 32'(sample_cnt), 3);
    chk("sat_xcnt",   32'(x_cnt),      0);
    chk("sat_data",   32'(out_data),   0);
    cnt_clr = 1'b1;
    in_data = 1'b1;
    step();
    cnt_clr  = 1'b0;
    in_valid = 1'b0;
    chk("clracc_sample", 32'(sample_cnt), 0);
    chk("clracc_valid",  32'(out_valid),  1);
    chk("clracc_data",   32'(out_data),   1);
    step();
    chk("clracc_drain", 32'(out_valid), 0);

    // unknown data capture
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 1'bx;
    step();
    in_valid = 1'b0;
    chk("xd_valid",  32'(out_valid),  1);
    chk("xd_sample", 32'(sample_cnt), 1);
    if (four_state) begin
      chk("xd_unknown", 32'(out_unknown), 1);
      chk("xd_xcnt",    32'(x_cnt),       1);
      chk("xd_xseen",   32'(x_seen),      1);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 1'b0;
    step();
    in_valid = 1'b0;
    chk("xk_data",   32'(out_data),   0);
    chk("xk_sample", 32'(sample_cnt), 2);
    chk("xk_unknown", 32'(out_unknown), 0);
    if (four_state) begin
      chk("xk_xseen", 32'(x_seen), 1);
      chk("xk_xcnt",  32'(x_cnt),  1);
    end
    step();
    chk("xk_drain",   32'(out_valid), 0);
    chk("pre_ctrl_x", 32'(ctrl_x),    0);

    // unknown in_valid
    out_ready = 1'b0;
    in_data   = 1'b1;
    in_valid  = 1'bx;
    step();
    in_valid = 1'b0;
    chk("cx_valid",  32'(out_valid),  0);
    chk("cx_sample", 32'(sample_cnt), 2);
    if (four_state)
      chk("cx_ctrl_x", 32'(ctrl_x), 1);

    // async reset while holding an unknown sample
    in_valid = 1'b1;
    in_data  = 1'bx;
    step();
    in_valid = 1'b0;
    chk("rf_valid", 32'(out_valid), 1);
    if (four_state)
      chk("rf_unknown", 32'(out_unknown), 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_valid",   32'(out_valid),   0);
    chk("ar_unknown", 32'(out_unknown), 0);
    chk("ar_data",    32'(out_data),    0);
    chk("ar_sample",  32'(sample_cnt),  0);
    chk("ar_xcnt",    32'(x_cnt),       0);
    chk("ar_xseen",   32'(x_seen),      0);
    chk("ar_ctrl_x",  32'(ctrl_x),      0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_valid",  32'(out_valid),  0);
    chk("post_rst_sample", 32'(sample_cnt), 0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/x_capture_monitor.md
X_CAPTURE_MONITOR -- requirements
Module: x_capture_monitor

Interface
REQ-001 Parameter WIDTH, default 1, bit width of the monitored data path.
REQ-002 Parameter CNT_W, default 8, width of the sample and unknown counters.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  upstream sample valid; it is the producer-side qualifier for the and-gate result path.
REQ-006 in_data  input  WIDTH  upstream sample, 4-state; may carry X/Z from unconnected instance inputs.
REQ-007 in_ready  output  1  monitor can accept a sample this cycle.
REQ-008 out_valid  output  1  held sample available downstream.
REQ-009 out_ready  input  1  downstream accepts the held sample.
REQ-010 out_data  output  WIDTH  held sample, raw; X/Z bits are preserved, not masked.
REQ-011 out_unknown  output  1  held sample contained at least one X or Z bit.
REQ-012 cnt_clr  input  1  synchronous clear of counters and sticky flags.
REQ-013 sample_cnt  output  CNT_W  count of accepted samples, saturating.
REQ-014 x_cnt  output  CNT_W  count of accepted samples with out_unknown set, saturating.
REQ-015 x_seen  output  1  sticky: any accepted sample was unknown since the last clear.
REQ-016 ctrl_x  output  1  sticky: in_valid or out_ready was X/Z on some rising edge.

Function
REQ-017 The block SHALL be a one-entry buffer with FSM states EMPTY and FULL.
REQ-018 in_ready SHALL equal (state==EMPTY) or (state==FULL and out_ready==1), combinationally.
REQ-019 out_valid SHALL be 1 exactly when state==FULL.
REQ-020 Accept SHALL occur when in_valid==1 and in_ready==1; in_data and its unknown flag are registered in the same edge.
REQ-021 Unknown detection SHALL use the 4-state reduction test (XOR-reduce of in_data is X) so a single X or Z bit sets the flag.
REQ-022 EMPTY with accept SHALL go to FULL; EMPTY without accept SHALL stay in EMPTY.
REQ-023 FULL with out_ready==1 and no accept SHALL go to EMPTY.
REQ-024 FULL with out_ready==1 and accept SHALL stay in FULL and replace the held sample, giving one transfer per cycle.
REQ-025 FULL with out_ready==0 SHALL hold out_data and out_unknown stable.
REQ-026 The monitor SHALL treat an X/Z on in_valid or out_ready as 0 for transfer purposes and SHALL set ctrl_x on that edge.
REQ-027 Latency SHALL be one cycle, from accept edge to out_valid high.
REQ-028 On each accept, sample_cnt SHALL increment by 1, and x_cnt SHALL increment when the flag is set; both hold at 2^CNT_W-1.
REQ-029 cnt_clr SHALL zero sample_cnt, x_cnt, x_seen and ctrl_x; when it coincides with an accept, the result is 0 and the accept is not counted.
REQ-030 cnt_clr SHALL NOT affect state, out_data or out_unknown.

Reset
REQ-031 With rst_n low, the block SHALL asynchronously force: state EMPTY, out_valid 0, out_data 0, out_unknown 0, both counters 0, x_seen 0, ctrl_x 0.
REQ-032 Reset asserted while FULL SHALL discard the held sample; the first edge after release follows EMPTY rules.

Structure
REQ-033 The state encodings EMPTY=0 and FULL=1 SHALL reside in the shared simulation-blocks package/include.
REQ-034 The unknown test SHALL live in one combinational sub-module, x_detect (WIDTH in, 1-bit out), reused for the data and control checks.

Verification
REQ-035 Known data: WIDTH=1, in_data=1, in_valid=1 for one cycle -> next cycle out_valid=1, out_data=1, out_unknown=0, sample_cnt=1, x_cnt=0.
REQ-036 Unconnected-input X: in_data=X, accepted -> out_unknown=1, x_cnt=1, x_seen=1; x_seen stays 1 after later known samples.
REQ-037 Back-pressure: FULL, out_ready=0, new in_valid -> in_ready=0 and out_data unchanged; then out_ready=1 and in_valid=1 with data 0 -> still FULL, out_data=0.
REQ-038 Saturation: CNT_W=2, 5 accepts -> sample_cnt=3; cnt_clr with an accept on the same edge -> sample_cnt=0.
REQ-039 Control X: in_valid=X for one edge -> no accept, state unchanged, ctrl_x=1.
REQ-040 Reset while FULL with out_unknown=1: pulse rst_n low mid-cycle -> out_valid, out_unknown and the counters read 0 at once, before any clock edge.
